div_iter: RTL and testbench

Iterative radix-2 restoring divider serving the MIPS DIV/DIVU instructions. It sits beside the execute stage. The execute stage holds `start_i` and stalls the pipeline until `ready_o` rises, then writes `result_o` into HI/LO through the existing whilo path. Operand width is parametrised, and the block supports signed/unsigned mode, annulment by a flushing branch delay slot, and a divide-by-zero shortcut.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_iter_if.sv | 22 ++
 rtl/div_step.sv | 29 ++
 rtl/div_iter.sv | 150 +++++++++++++++
 tb/tb_div_iter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states and EX handshake constants.
// They sit beside the EXE_DIV_OP / EXE_DIVU_OP AluOp defines.
package div_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring iteration on magnitudes: shift {rem, quo} left one bit,
// then trial-subtract the divisor from the upper WIDTH+1 bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // A clear MSB on the difference means the shifted remainder covered the divisor.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor_i};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_o = diff_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Operands are captured on the start edge; sign fix-up happens in one final ON cycle.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               neg1_s, neg2_s;
  logic [WIDTH-1:0]   abs1_s, abs2_s;
  logic [WIDTH-1:0]   step_rem_s, step_quo_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Operand magnitudes and signed-mode result correction.
  always_comb begin
    neg1_s    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    neg2_s    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1_s    = neg1_s ? ({WIDTH{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
    abs2_s    = neg2_s ? ({WIDTH{1'b0}} - bus.opdata2_i) : bus.opdata2_i;
    quo_fix_s = (signed_q & (sign1_q ^ sign2_q)) ? ({WIDTH{1'b0}} - quo_q) : quo_q;
    rem_fix_s = (signed_q & sign1_q) ? ({WIDTH{1'b0}} - rem_q) : rem_q;
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    signed_d = signed_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      FREE: begin
        ready_d  = DivResultNotReady;
        result_d = {(2*WIDTH){1'b0}};
        if ((bus.start_i == DivStart) && (bus.annul_i == 1'b0)) begin
          if (bus.opdata2_i == {WIDTH{1'b0}}) begin
            state_d = BY_ZERO;
          end else begin
            state_d  = ON;
            quo_d    = abs1_s;
            dvs_d    = abs2_s;
            sign1_d  = bus.opdata1_i[WIDTH-1];
            sign2_d  = bus.opdata2_i[WIDTH-1];
            signed_d = bus.signed_div_i;
            cnt_d    = {CW{1'b0}};
            rem_d    = {WIDTH{1'b0}};
          end
        end else begin
          state_d = FREE;
        end
      end
      BY_ZERO: begin
        state_d  = END;
        result_d = {(2*WIDTH){1'b0}};
        ready_d  = DivResultReady;
      end
      ON: begin
        if ((bus.annul_i == 1'b1) || (bus.start_i == DivStop)) begin
          state_d  = FREE;
          ready_d  = DivResultNotReady;
          result_d = {(2*WIDTH){1'b0}};
        end else if (cnt_q != CNT_LAST) begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + CW'(1);
        end else begin
          result_d = {rem_fix_s, quo_fix_s};
          ready_d  = DivResultReady;
          state_d  = END;
        end
      end
      END: begin
        if (bus.start_i == DivStop) begin
          state_d  = FREE;
          ready_d  = DivResultNotReady;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          ready_d = DivResultReady;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = DivResultNotReady;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      signed_q <= signed_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench: WIDTH=32 and WIDTH=8 dividers against an arithmetic reference model.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  div_iter_if #(.WIDTH(32)) bus32 ();
  div_iter_if #(.WIDTH(8))  bus8 ();

  div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] mask, qv, rv;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    if ((64'(b) & mask) == 64'd0) return 64'd0;
    if (sgn) begin
      if (w == 32) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'($signed(a[7:0]));
        sb = longint'($signed(b[7:0]));
      end
    end else begin
      sa = longint'(64'(a) & mask);
      sb = longint'(64'(b) & mask);
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q) & mask;
    rv = 64'(r) & mask;
    return (rv << w) | qv;
  endfunction

  task automatic drive(input bit narrow, input logic st, input logic an, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b);
    if (narrow) begin
      bus8.start_i = st; bus8.annul_i = an; bus8.signed_div_i = sgn;
      bus8.opdata1_i = a[7:0]; bus8.opdata2_i = b[7:0];
    end else begin
      bus32.start_i = st; bus32.annul_i = an; bus32.signed_div_i = sgn;
      bus32.opdata1_i = a; bus32.opdata2_i = b;
    end
  endtask

  task automatic sample(input bit narrow, output logic rdy, output logic [63:0] res);
    if (narrow) begin
      rdy = bus8.ready_o;
      res = {48'd0, bus8.result_o};
    end else begin
      rdy = bus32.ready_o;
      res = {32'd0, bus32.result_o};
    end
  endtask

  // One full operation: latency, result, stability while held (annul toggled), clear after drop.
  task automatic run_op(input bit narrow, input bit sgn, input logic [31:0] a_in,
                        input logic [31:0] b_in, input string tag, input int hold);
    int w, exp_lat, lat;
    logic [31:0] a, b;
    logic [63:0] exp, res;
    logic rdy;
    w = narrow ? 8 : 32;
    a = narrow ? (a_in & 32'h0000_00FF) : a_in;
    b = narrow ? (b_in & 32'h0000_00FF) : b_in;
    exp = ref_div(w, sgn, a, b);
    exp_lat = (b == 32'd0) ? 2 : w + 2;
    lat = 0;
    res = 64'd0;
    @(negedge clk);
    drive(narrow, 1'b1, 1'b0, sgn, a, b);
    for (int n = 1; n <= w + 8 && lat == 0; n++) begin
      @(posedge clk); #1;
      sample(narrow, rdy, res);
      if (n == 1) drive(narrow, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (rdy) lat = n;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, res, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      drive(narrow, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      @(posedge clk); #1;
      sample(narrow, rdy, res);
      check({tag, "_hold_ready"}, 64'(rdy), 64'd1);
      check({tag, "_hold_result"}, res, exp);
    end
    @(negedge clk);
    drive(narrow, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    sample(narrow, rdy, res);
    check({tag, "_clr_ready"}, 64'(rdy), 64'd0);
    check({tag, "_clr_result"}, res, 64'd0);
  endtask

  // Count ready pulses on the 32-bit divider over a quiet window.
  task automatic count_ready(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (bus32.ready_o) seen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rdy;
    logic [63:0] res;
    int seen;
    logic [31:0] ra, rb;
    bit nar;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(1'b0, rdy, res);
    check("reset32_ready", 64'(rdy), 64'd0);
    check("reset32_result", res, 64'd0);
    sample(1'b1, rdy, res);
    check("reset8_ready", 64'(rdy), 64'd0);
    check("reset8_result", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'd100, 32'd7, "u100_7", 3);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", 1);
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2", 1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_minneg_m1", 1);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "u_minneg_m1", 1);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, "u_by_zero", 2);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, "s_by_zero", 1);
    run_op(1'b1, 1'b0, 32'd200, 32'd13, "w8_200_13", 2);

    // Annul in cycle 10: no result may ever appear, then a fresh op must run normally.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    count_ready(40, seen);
    check("annul_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 1'b0, 32'd9, 32'd3, "after_annul", 1);

    // Reset in cycle 20 mid-division.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd12345, 32'd11);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sample(1'b0, rdy, res);
    check("rst_on_ready", 64'(rdy), 64'd0);
    check("rst_on_result", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    count_ready(40, seen);
    check("rst_no_ready", 64'(seen), 64'd0);

    // Reset while a finished result is being held.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd200, 32'd13);
    repeat (12) @(posedge clk);
    #1;
    sample(1'b1, rdy, res);
    check("w8_end_ready", 64'(rdy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sample(1'b1, rdy, res);
    check("rst_end_ready", 64'(rdy), 64'd0);
    check("rst_end_result", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_op(1'b0, 1'b0, 32'd1000, 32'd3, "after_rst", 1);

    for (int i = 0; i < 30; i++) begin
      nar = 1'(i % 2);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = nar ? 32'h0000_0080 : 32'h8000_0000;
      run_op(nar, 1'($urandom_range(0, 1)), ra, rb, "rnd", int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
